// File: rtl/airi5c_fpu_issue_ctrl.sv
// airi5c_fpu_issue_ctrl: pipeline-side initiator for the airi5c FPU core.
// Accepts one OP-FP instruction at a time and decodes it into a one-hot op and a rounding mode.
// It issues a single-cycle load, waits for ready, and presents a one-cycle writeback.
// FMV.X.W / FMV.W.X complete locally. Pipeline flushes propagate to the core as kill.
// Optional: define AIRI5C_FPU_ISSUE_TIMEOUT_EN to add a BUSY watchdog bounded by TIMEOUT_CYCLES.
module airi5c_fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  input  logic [31:0] instr,
  input  logic [2:0]  frm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        kill_in,
  output logic        stall,
  output logic        illegal,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        wb_to_int,
  output logic [4:0]  fflags_set,
  output logic        fpu_load,
  output logic        fpu_kill,
  output logic [17:0] fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  input  logic        fpu_ready,
  output logic        timeout_err
);

  // One-hot op bit positions on the core op bus.
  localparam int unsigned OpAdd   = 0;
  localparam int unsigned OpSub   = 1;
  localparam int unsigned OpMul   = 2;
  localparam int unsigned OpDiv   = 3;
  localparam int unsigned OpSqrt  = 4;
  localparam int unsigned OpSgnj  = 5;
  localparam int unsigned OpSgnjn = 6;
  localparam int unsigned OpSgnjx = 7;
  localparam int unsigned OpCvtfi = 8;
  localparam int unsigned OpCvtfu = 9;
  localparam int unsigned OpCvtif = 10;
  localparam int unsigned OpCvtuf = 11;
  localparam int unsigned OpEq    = 12;
  localparam int unsigned OpLt    = 13;
  localparam int unsigned OpLe    = 14;
  localparam int unsigned OpClass = 15;
  localparam int unsigned OpMin   = 16;
  localparam int unsigned OpMax   = 17;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

  state_e      state_q;
  logic [17:0] op_q;
  logic [2:0]  rm_q;
  logic [31:0] a_q, b_q, data_q;
  logic [4:0]  flags_q;
  logic        to_int_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs2_fld;
  logic [17:0] dec_op;
  logic        dec_bypass, dec_uses_rm, dec_to_int, dec_rm_bad, dec_legal;
  logic [2:0]  dec_rm;
  logic        timeout;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign rs2_fld = instr[24:20];
  assign funct7  = instr[31:25];

  // Register fields are resolved by the pipeline, not here.
  logic unused_instr;
  assign unused_instr = ^{instr[19:15], instr[11:7]};

  // Decode the instruction word into op, rounding-mode usage and destination.
  always_comb begin
    dec_op      = '0;
    dec_bypass  = 1'b0;
    dec_uses_rm = 1'b0;
    dec_to_int  = 1'b0;
    if (opcode == 7'b1010011) begin
      case (funct7)
        7'b0000000: begin dec_op[OpAdd] = 1'b1; dec_uses_rm = 1'b1; end
        7'b0000100: begin dec_op[OpSub] = 1'b1; dec_uses_rm = 1'b1; end
        7'b0001000: begin dec_op[OpMul] = 1'b1; dec_uses_rm = 1'b1; end
        7'b0001100: begin dec_op[OpDiv] = 1'b1; dec_uses_rm = 1'b1; end
        7'b0101100: begin
          if (rs2_fld == 5'd0) begin
            dec_op[OpSqrt] = 1'b1;
            dec_uses_rm    = 1'b1;
          end
        end
        7'b0010000: begin
          case (funct3)
            3'b000:  dec_op[OpSgnj]  = 1'b1;
            3'b001:  dec_op[OpSgnjn] = 1'b1;
            3'b010:  dec_op[OpSgnjx] = 1'b1;
            default: ;
          endcase
        end
        7'b0010100: begin
          case (funct3)
            3'b000:  dec_op[OpMin] = 1'b1;
            3'b001:  dec_op[OpMax] = 1'b1;
            default: ;
          endcase
        end
        7'b1100000: begin
          dec_uses_rm = 1'b1;
          dec_to_int  = 1'b1;
          if (rs2_fld == 5'd0) dec_op[OpCvtfi] = 1'b1;
          if (rs2_fld == 5'd1) dec_op[OpCvtfu] = 1'b1;
        end
        7'b1101000: begin
          dec_uses_rm = 1'b1;
          if (rs2_fld == 5'd0) dec_op[OpCvtif] = 1'b1;
          if (rs2_fld == 5'd1) dec_op[OpCvtuf] = 1'b1;
        end
        7'b1010000: begin
          dec_to_int = 1'b1;
          case (funct3)
            3'b010:  dec_op[OpEq] = 1'b1;
            3'b001:  dec_op[OpLt] = 1'b1;
            3'b000:  dec_op[OpLe] = 1'b1;
            default: ;
          endcase
        end
        7'b1110000: begin
          dec_to_int = 1'b1;
          if (rs2_fld == 5'd0 && funct3 == 3'b001) dec_op[OpClass] = 1'b1;
          if (rs2_fld == 5'd0 && funct3 == 3'b000) dec_bypass = 1'b1;
        end
        7'b1111000: begin
          if (rs2_fld == 5'd0 && funct3 == 3'b000) dec_bypass = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // funct3 = 111 selects the dynamic mode; reserved results make the instruction illegal.
  assign dec_rm     = !dec_uses_rm ? 3'b000 : (funct3 == 3'b111) ? frm : funct3;
  assign dec_rm_bad = dec_rm[2] & (dec_rm[1] | dec_rm[0]);
  assign dec_legal  = ((|dec_op) | dec_bypass) & !dec_rm_bad;

`ifdef AIRI5C_FPU_ISSUE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] busy_cnt_q;

  // Count BUSY cycles; restarts at zero on every entry into BUSY.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      busy_cnt_q <= '0;
    end else if (state_q != StBusy) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_q + CntW'(1);
    end
  end

  // Fires in the TIMEOUT_CYCLES-th BUSY cycle if the core has still not answered.
  assign timeout = (state_q == StBusy) & !fpu_ready & !kill_in &
                   (busy_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Control FSM plus the operand, result and flag registers it owns.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      flags_q  <= '0;
      to_int_q <= 1'b0;
    end else if (kill_in) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && dec_legal) begin
            to_int_q <= dec_to_int;
            if (dec_bypass) begin
              data_q  <= rs1_data;
              flags_q <= '0;
              state_q <= StDone;
            end else begin
              op_q    <= dec_op;
              rm_q    <= dec_rm;
              a_q     <= rs1_data;
              b_q     <= rs2_data;
              state_q <= StIssue;
            end
          end
        end
        StIssue: state_q <= StBusy;
        StBusy: begin
          if (timeout) begin
            state_q <= StIdle;
          end else if (fpu_ready) begin
            data_q  <= fpu_result;
            flags_q <= fpu_flags;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode from the registered state.
  assign illegal     = (state_q == StIdle) & req_valid & !kill_in & !dec_legal;
  assign stall       = req_valid & (state_q != StDone) & !illegal & !kill_in;
  assign fpu_load    = (state_q == StIssue);
  assign fpu_op      = ((state_q == StIssue) || (state_q == StBusy)) ? op_q : '0;
  assign fpu_rm      = rm_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign fpu_kill    = kill_in | timeout;
  assign timeout_err = timeout;
  assign wb_valid    = (state_q == StDone) & !kill_in;
  assign wb_data     = data_q;
  assign wb_to_int   = to_int_q;
  assign fflags_set  = wb_valid ? flags_q : 5'b00000;

endmodule

// File: tb/tb_airi5c_fpu_issue_ctrl.sv
// tb_airi5c_fpu_issue_ctrl: scoreboard bench for the FPU issue controller.
// Expected writebacks are queued when an instruction is accepted and popped on wb_valid.
module tb_airi5c_fpu_issue_ctrl;

  logic        clk, n_reset;
  logic        req_valid, kill_in, fpu_ready;
  logic [31:0] instr, rs1_data, rs2_data, fpu_result;
  logic [2:0]  frm;
  logic [4:0]  fpu_flags;
  logic        stall, illegal, wb_valid, wb_to_int, fpu_load, fpu_kill, timeout_err;
  logic [31:0] wb_data, fpu_a, fpu_b;
  logic [4:0]  fflags_set;
  logic [17:0] fpu_op;
  logic [2:0]  fpu_rm;

  typedef struct packed {
    logic [31:0] data;
    logic        to_int;
    logic [4:0]  flags;
  } wb_t;

  wb_t sb_q[$];
  wb_t mon_exp;
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_loads = 0;
  int  exp_loads = 0;

  airi5c_fpu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .req_valid  (req_valid),
    .instr      (instr),
    .frm        (frm),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .kill_in    (kill_in),
    .stall      (stall),
    .illegal    (illegal),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_to_int  (wb_to_int),
    .fflags_set (fflags_set),
    .fpu_load   (fpu_load),
    .fpu_kill   (fpu_kill),
    .fpu_op     (fpu_op),
    .fpu_rm     (fpu_rm),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .fpu_flags  (fpu_flags),
    .fpu_ready  (fpu_ready),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [2:0] f3);
    return {f7, r2, 5'd1, f3, 5'd2, 7'b1010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full FPU transaction; the core answers in BUSY cycle 'delay' (>= 1).
  task automatic run_fpu(input string tag, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input int unsigned delay,
                         input logic [31:0] res, input logic [4:0] flg, input logic to_int,
                         input logic [17:0] op, input logic [2:0] rm);
    wb_t e;
    step();
    req_valid = 1'b1; instr = ins; rs1_data = a; rs2_data = b;
    @(negedge clk);
    check_eq({tag, "_acc_stall"}, 32'(stall), 1);
    check_eq({tag, "_acc_illegal"}, 32'(illegal), 0);
    e.data = res; e.to_int = to_int; e.flags = flg;
    sb_q.push_back(e);
    exp_loads++;
    // ISSUE: a stray ready with junk must be ignored.
    step();
    fpu_ready = 1'b1; fpu_result = 32'hBAD0BAD0; fpu_flags = 5'h1f;
    @(negedge clk);
    check_eq({tag, "_load"}, 32'(fpu_load), 1);
    check_eq({tag, "_op"}, 32'(fpu_op), 32'(op));
    check_eq({tag, "_rm"}, 32'(fpu_rm), 32'(rm));
    check_eq({tag, "_a"}, fpu_a, a);
    check_eq({tag, "_b"}, fpu_b, b);
    step();
    fpu_ready = 1'b0; fpu_result = '0; fpu_flags = '0;
    for (int i = 1; i < int'(delay); i++) begin
      @(negedge clk);
      check_eq({tag, "_busy_stall"}, 32'(stall), 1);
      check_eq({tag, "_busy_op"}, 32'(fpu_op), 32'(op));
      check_eq({tag, "_busy_tmo"}, 32'(timeout_err), 0);
      check_eq({tag, "_busy_wb"}, 32'(wb_valid), 0);
      step();
    end
    fpu_ready = 1'b1; fpu_result = res; fpu_flags = flg;
    @(negedge clk);
    check_eq({tag, "_load_once"}, 32'(fpu_load), 0);
    check_eq({tag, "_hold_op"}, 32'(fpu_op), 32'(op));
    step();
    fpu_ready = 1'b0; fpu_result = '0; fpu_flags = '0;
    @(negedge clk);
    check_eq({tag, "_wb"}, 32'(wb_valid), 1);
    check_eq({tag, "_done_stall"}, 32'(stall), 0);
    check_eq({tag, "_done_op"}, 32'(fpu_op), 0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_wb_one"}, 32'(wb_valid), 0);
  endtask

  task automatic run_bypass(input string tag, input logic [31:0] ins, input logic [31:0] a,
                            input logic to_int);
    wb_t e;
    step();
    req_valid = 1'b1; instr = ins; rs1_data = a; rs2_data = 32'h5555AAAA;
    @(negedge clk);
    check_eq({tag, "_acc_stall"}, 32'(stall), 1);
    e.data = a; e.to_int = to_int; e.flags = '0;
    sb_q.push_back(e);
    step();
    @(negedge clk);
    check_eq({tag, "_wb"}, 32'(wb_valid), 1);
    check_eq({tag, "_load"}, 32'(fpu_load), 0);
    check_eq({tag, "_stall"}, 32'(stall), 0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_wb_one"}, 32'(wb_valid), 0);
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ins, input logic [2:0] f);
    step();
    req_valid = 1'b1; instr = ins; frm = f;
    @(negedge clk);
    check_eq({tag, "_illegal"}, 32'(illegal), 1);
    check_eq({tag, "_stall"}, 32'(stall), 0);
    step();
    @(negedge clk);
    check_eq({tag, "_no_load"}, 32'(fpu_load), 0);
    step();
    req_valid = 1'b0; frm = 3'b000;
    @(negedge clk);
    check_eq({tag, "_clear"}, 32'(illegal), 0);
  endtask

  // Writeback monitor: every wb_valid must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1) begin
        if (fpu_load === 1'b1) n_loads++;
        if (wb_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            check_eq("wb_unexpected", 32'(wb_valid), 0);
          end else begin
            mon_exp = sb_q.pop_front();
            check_eq("wb_data", wb_data, mon_exp.data);
            check_eq("wb_to_int", 32'(wb_to_int), 32'(mon_exp.to_int));
            check_eq("wb_flags", 32'(fflags_set), 32'(mon_exp.flags));
          end
        end else begin
          check_eq("fflags_idle", 32'(fflags_set), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  initial begin
    n_reset = 1'b0; req_valid = 1'b0; kill_in = 1'b0; fpu_ready = 1'b0;
    instr = '0; rs1_data = '0; rs2_data = '0; fpu_result = '0; frm = '0; fpu_flags = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_wb", 32'(wb_valid), 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_to_int", 32'(wb_to_int), 0);
    check_eq("rst_op", 32'(fpu_op), 0);
    check_eq("rst_rm", 32'(fpu_rm), 0);
    check_eq("rst_a", fpu_a, 0);
    check_eq("rst_b", fpu_b, 0);
    check_eq("rst_load", 32'(fpu_load), 0);
    check_eq("rst_kill", 32'(fpu_kill), 0);
    check_eq("rst_tmo", 32'(timeout_err), 0);
    check_eq("rst_fflags", 32'(fflags_set), 0);
    step();
    n_reset = 1'b1;

    run_fpu("fadd", mk(7'b0000000, 5'd2, 3'b000), 32'h3F800000, 32'h40000000, 4,
            32'h40400000, 5'b00000, 1'b0, 18'h00001, 3'b000);
    run_bypass("fmvxw", mk(7'b1110000, 5'd0, 3'b000), 32'hDEADBEEF, 1'b1);
    run_bypass("fmvwx", mk(7'b1111000, 5'd0, 3'b000), 32'h12345678, 1'b0);
    run_illegal("fadd_dyn101", mk(7'b0000000, 5'd2, 3'b111), 3'b101);
    frm = 3'b001;
    run_fpu("fadd_dyn", mk(7'b0000000, 5'd2, 3'b111), 32'h40000000, 32'h40000000, 1,
            32'h40800000, 5'b00001, 1'b0, 18'h00001, 3'b001);
    frm = 3'b000;
    run_fpu("fdiv0", mk(7'b0001100, 5'd2, 3'b000), 32'h3F800000, 32'h00000000, 2,
            32'h7F800000, 5'b01000, 1'b0, 18'h00008, 3'b000);
    run_fpu("feq", mk(7'b1010000, 5'd2, 3'b010), 32'h3F800000, 32'h3F800000, 3,
            32'h00000001, 5'b00000, 1'b1, 18'h01000, 3'b000);
    run_fpu("fcvtws", mk(7'b1100000, 5'd0, 3'b001), 32'h40490FDB, 32'h0, 2,
            32'h00000003, 5'b00001, 1'b1, 18'h00100, 3'b001);
    run_fpu("fmax", mk(7'b0010100, 5'd2, 3'b001), 32'hBF800000, 32'h3F800000, 1,
            32'h3F800000, 5'b00000, 1'b0, 18'h20000, 3'b000);
    run_fpu("fclass", mk(7'b1110000, 5'd0, 3'b001), 32'h7FC00000, 32'h0, 2,
            32'h00000200, 5'b00000, 1'b1, 18'h08000, 3'b000);
    run_fpu("fsgnjx", mk(7'b0010000, 5'd2, 3'b010), 32'h3F800000, 32'hBF800000, 1,
            32'hBF800000, 5'b00000, 1'b0, 18'h00080, 3'b000);

    run_illegal("bad_opc", 32'h00000013, 3'b000);
    run_illegal("sqrt_rs2", mk(7'b0101100, 5'd1, 3'b000), 3'b000);
    run_illegal("sgnj_f3", mk(7'b0010000, 5'd2, 3'b011), 3'b000);
    run_illegal("cvt_rs2", mk(7'b1100000, 5'd2, 3'b000), 3'b000);
    run_illegal("rm_110", mk(7'b0001000, 5'd2, 3'b110), 3'b000);

    // FSQRT killed in its 2nd BUSY cycle; the late ready lands in IDLE.
    step();
    req_valid = 1'b1; instr = mk(7'b0101100, 5'd0, 3'b000); rs1_data = 32'h40800000;
    exp_loads++;
    step();
    step();
    @(negedge clk);
    check_eq("sqrt_no_kill", 32'(fpu_kill), 0);
    step();
    kill_in = 1'b1;
    @(negedge clk);
    check_eq("sqrt_kill", 32'(fpu_kill), 1);
    check_eq("sqrt_kill_stall", 32'(stall), 0);
    step();
    kill_in = 1'b0; req_valid = 1'b0;
    fpu_ready = 1'b1; fpu_result = 32'hCAFEF00D; fpu_flags = 5'b10000;
    @(negedge clk);
    check_eq("sqrt_idle_op", 32'(fpu_op), 0);
    check_eq("sqrt_idle_kill", 32'(fpu_kill), 0);
    step();
    fpu_ready = 1'b0; fpu_result = '0; fpu_flags = '0;
    @(negedge clk);
    check_eq("sqrt_late_ready_wb", 32'(wb_valid), 0);
    run_fpu("fmul_after_kill", mk(7'b0001000, 5'd2, 3'b000), 32'h40000000, 32'h40400000, 2,
            32'h40C00000, 5'b00000, 1'b0, 18'h00004, 3'b000);

    // Kill together with a legal request in IDLE: nothing accepted.
    step();
    req_valid = 1'b1; kill_in = 1'b1; instr = mk(7'b0000000, 5'd2, 3'b000);
    @(negedge clk);
    check_eq("kidle_stall", 32'(stall), 0);
    check_eq("kidle_illegal", 32'(illegal), 0);
    check_eq("kidle_kill", 32'(fpu_kill), 1);
    step();
    req_valid = 1'b0; kill_in = 1'b0;
    @(negedge clk);
    check_eq("kidle_no_load", 32'(fpu_load), 0);

    // Kill in DONE suppresses the writeback.
    step();
    req_valid = 1'b1; instr = mk(7'b1111000, 5'd0, 3'b000); rs1_data = 32'hA5A5A5A5;
    step();
    kill_in = 1'b1;
    @(negedge clk);
    check_eq("kdone_wb", 32'(wb_valid), 0);
    check_eq("kdone_kill", 32'(fpu_kill), 1);
    step();
    kill_in = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check_eq("kdone_wb_after", 32'(wb_valid), 0);

`ifdef AIRI5C_FPU_ISSUE_TIMEOUT_EN
    // Core never answers: watchdog fires in the 8th BUSY cycle.
    step();
    req_valid = 1'b1; instr = mk(7'b0001100, 5'd2, 3'b000); rs1_data = 32'h3F800000;
    exp_loads++;
    step();
    step();
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check_eq("tmo_early", 32'(timeout_err), 0);
      step();
    end
    @(negedge clk);
    check_eq("tmo_err", 32'(timeout_err), 1);
    check_eq("tmo_kill", 32'(fpu_kill), 1);
    check_eq("tmo_wb", 32'(wb_valid), 0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("tmo_pulse", 32'(timeout_err), 0);
    check_eq("tmo_idle_op", 32'(fpu_op), 0);
    check_eq("tmo_idle_wb", 32'(wb_valid), 0);
`else
    // Without the watchdog a slow core is simply waited for.
    run_fpu("slow", mk(7'b0000100, 5'd2, 3'b000), 32'h40400000, 32'h3F800000, 20,
            32'h40000000, 5'b00000, 1'b0, 18'h00002, 3'b000);
`endif

    step();
    @(negedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 0);
    check_eq("load_count", 32'(n_loads), 32'(exp_loads));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
